ir_transmit: RTL and testbench

NEC-format infrared transmitter: the encoder counterpart of the IR receive path. Accepts a 32-bit word through a valid/ready handshake and serialises it as a complete NEC frame on an IR LED drive pin: leader mark, leader space, 32 pulse-distance bits LSB first, stop mark, then a mandatory inter-frame gap. Bit order and word layout match what IR_RECEIVE reports on `oDATA`, so a word sent here decodes to the same word on a receiving board. Sits beside the UART and FSM logic in top level and is driven by FSM or UART commands.

---
 rtl/ir_transmit.sv | 170 +++++++++++++++++
 tb/tb_ir_transmit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_transmit.sv
// NEC-format IR transmitter: leader mark/space, 32 pulse-distance bits LSB first, stop mark, forced gap.
// Optional macro IR_TX_CARRIER_EN gates the marks with a CARRIER_HALF-period carrier; otherwise oIRDA is the bare envelope.
module ir_transmit #(
    parameter int TICKS_PER_UNIT = 28125,
    parameter int CARRIER_HALF   = 658,
    parameter int GAP_UNITS      = 72
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [31:0] iDATA,
    input  logic        iVALID,
    output logic        oREADY,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oIRDA
);
    localparam int UNIT_W    = $clog2(TICKS_PER_UNIT);
    localparam int MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
    localparam int LEN_W     = $clog2(MAX_UNITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_GAP
    } state_t;

    state_t              r_state;
    logic [UNIT_W-1:0]   r_unit_cnt;
    logic [LEN_W-1:0]    r_len_cnt;
    logic [4:0]          r_bit_idx;
    logic [31:0]         r_shift;
    logic                r_env;
    logic                r_ready;
    logic                r_done;

    logic [LEN_W-1:0]    w_len_last;
    logic                w_last_unit;
    logic                w_unit_end;
    logic                w_state_end;
    logic                w_pre_end;

    // Index of the final unit of the current state; a '1' bit stretches its space to three units.
    always_comb begin
        w_len_last = '0;
        case (r_state)
            S_LEAD_MARK:  w_len_last = LEN_W'(15);
            S_LEAD_SPACE: w_len_last = LEN_W'(7);
            S_BIT_SPACE:  w_len_last = r_shift[0] ? LEN_W'(2) : '0;
            S_GAP:        w_len_last = LEN_W'(GAP_UNITS - 1);
            default:      w_len_last = '0;
        endcase
    end

    assign w_last_unit = (r_len_cnt == w_len_last);
    assign w_unit_end  = (r_unit_cnt == UNIT_W'(TICKS_PER_UNIT - 1));
    assign w_state_end = w_last_unit && w_unit_end;
    assign w_pre_end   = w_last_unit && (r_unit_cnt == UNIT_W'(TICKS_PER_UNIT - 2));

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state    <= S_IDLE;
            r_unit_cnt <= '0;
            r_len_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_env      <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_unit_cnt <= '0;
            r_len_cnt  <= '0;
            r_done     <= 1'b0;
            if (iVALID) begin
                r_shift   <= iDATA;
                r_bit_idx <= '0;
                r_state   <= S_LEAD_MARK;
                r_env     <= 1'b1;
                r_ready   <= 1'b0;
            end
        end else begin
            // oDONE is registered one cycle early so it lands on the final gap cycle.
            r_done <= (r_state == S_GAP) && w_pre_end;
            if (!w_state_end) begin
                if (w_unit_end) begin
                    r_unit_cnt <= '0;
                    r_len_cnt  <= r_len_cnt + LEN_W'(1);
                end else begin
                    r_unit_cnt <= r_unit_cnt + UNIT_W'(1);
                end
            end else begin
                r_unit_cnt <= '0;
                r_len_cnt  <= '0;
                case (r_state)
                    S_LEAD_MARK: begin
                        r_state <= S_LEAD_SPACE;
                        r_env   <= 1'b0;
                    end
                    S_LEAD_SPACE: begin
                        r_state <= S_BIT_MARK;
                        r_env   <= 1'b1;
                    end
                    S_BIT_MARK: begin
                        r_state <= S_BIT_SPACE;
                        r_env   <= 1'b0;
                    end
                    S_BIT_SPACE: begin
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= r_bit_idx + 5'd1;
                        r_env     <= 1'b1;
                        r_state   <= (r_bit_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                    end
                    S_STOP_MARK: begin
                        r_state <= S_GAP;
                        r_env   <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_env   <= 1'b0;
                        r_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef IR_TX_CARRIER_EN
    localparam int CAR_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    logic [CAR_W-1:0] r_car_cnt;
    logic             r_irda;
    logic             w_enter_mark;

    assign w_enter_mark = ((r_state == S_IDLE) && iVALID) ||
                          (w_state_end && ((r_state == S_LEAD_SPACE) || (r_state == S_BIT_SPACE)));

    // Carrier phase restarts high on the first cycle of every mark; r_env marks the mark states.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_car_cnt <= '0;
            r_irda    <= 1'b0;
        end else if (w_enter_mark) begin
            r_car_cnt <= '0;
            r_irda    <= 1'b1;
        end else if (r_env && !w_state_end) begin
            if (r_car_cnt == CAR_W'(CARRIER_HALF - 1)) begin
                r_car_cnt <= '0;
                r_irda    <= ~r_irda;
            end else begin
                r_car_cnt <= r_car_cnt + CAR_W'(1);
            end
        end else begin
            r_car_cnt <= '0;
            r_irda    <= 1'b0;
        end
    end

    assign oIRDA = r_irda;
`else
    assign oIRDA = r_env;
`endif

    assign oREADY = r_ready;
    assign oBUSY  = ~r_ready;
    assign oDONE  = r_done;

endmodule

// File: tb/tb_ir_transmit.sv
// Bench for ir_transmit: cycle-exact envelope model per frame, plus a behavioural NEC decoder
// that pops expected words from a scoreboard queue as frames complete on oIRDA.
`timescale 1ns/1ps
module tb_ir_transmit;
    localparam int T   = 4;
    localparam int CH  = 1;
    localparam int GAP = 3;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [31:0] iDATA  = '0;
    logic        iVALID = 1'b0;
    logic        oREADY;
    logic        oBUSY;
    logic        oDONE;
    logic        oIRDA;

    always #5 clk = ~clk;

    ir_transmit #(
        .TICKS_PER_UNIT(T),
        .CARRIER_HALF  (CH),
        .GAP_UNITS     (GAP)
    ) dut (
        .iCLK  (clk),
        .iRST_n(rst_n),
        .iDATA (iDATA),
        .iVALID(iVALID),
        .oREADY(oREADY),
        .oBUSY (oBUSY),
        .oDONE (oDONE),
        .oIRDA (oIRDA)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Independent frame-length model: leader 24 units, each bit 2 or 4 units, stop 1 unit.
    function automatic int frame_cycles(input logic [31:0] w);
        int u = 16 + 8 + 1;
        for (int i = 0; i < 32; i++) u += w[i] ? 4 : 2;
        return u * T;
    endfunction

    logic [31:0] exp_q[$];

`ifdef IR_TX_CARRIER_EN
    function automatic logic mark_lvl(input int k);
        return ((k / CH) % 2) == 0;
    endfunction
`else
    function automatic logic mark_lvl(input int k);
        return (k >= 0);
    endfunction

    int          dec_frames = 0;
    int          dec_err    = 0;
    int          dec_bits   = 0;
    int          dec_state  = 0;
    int          run_len    = 0;
    int          t_cnt      = 0;
    int          frame_t0   = 0;
    int          last_space = 0;
    int          lead_gap   = 0;
    logic        prev_lvl   = 1'b0;
    logic [31:0] dec_word   = '0;
    int          dec_space[32];

    // Behavioural NEC receiver fed straight from the envelope (wire loopback).
    always @(negedge clk) begin
        if (!rst_n) begin
            dec_state = 0;
            dec_bits  = 0;
            prev_lvl  = 1'b0;
            run_len   = 0;
        end else begin
            if (oIRDA === prev_lvl) begin
                run_len++;
            end else begin
                if (prev_lvl) begin
                    if (run_len == 16 * T) begin
                        dec_state = 1;
                        dec_bits  = 0;
                        frame_t0  = t_cnt - run_len;
                        lead_gap  = last_space;
                    end else if (dec_state == 2 && run_len == T) begin
                        if (dec_bits == 32) begin
                            dec_frames++;
                            $display("decoded frame %0d word %h length %0d", dec_frames, dec_word, t_cnt - frame_t0);
                            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
                            if (exp_q.size() > 0) begin
                                logic [31:0] w;
                                w = exp_q.pop_front();
                                check("decoded_word", dec_word, w);
                                check("frame_length", t_cnt - frame_t0, frame_cycles(w));
                            end
                            dec_state = 0;
                        end else begin
                            dec_state = 3;
                        end
                    end else if (dec_state != 0) begin
                        dec_err++;
                        dec_state = 0;
                    end
                end else begin
                    last_space = run_len;
                    if (dec_state == 1 && run_len == 8 * T) begin
                        dec_state = 2;
                    end else if (dec_state == 3 && (run_len == T || run_len == 3 * T)) begin
                        dec_space[dec_bits] = run_len;
                        dec_word[dec_bits]  = (run_len == 3 * T);
                        dec_bits++;
                        dec_state = 2;
                    end else if (dec_state != 0) begin
                        dec_err++;
                        dec_state = 0;
                    end
                end
                prev_lvl = oIRDA;
                run_len  = 1;
            end
            t_cnt++;
        end
    end

    task automatic wait_frames(input int n);
        int k = 0;
        while (dec_frames < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("frame_count", dec_frames, n);
    endtask
`endif

    task automatic accept(input logic [31:0] w);
        int k = 0;
        @(negedge clk);
        while (oREADY !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_accept", oREADY, 1);
        iDATA  = w;
        iVALID = 1'b1;
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        iVALID = 1'b0;
        iDATA  = $urandom;
    endtask

    logic env_q[$];

    task automatic push_seg(input bit mark, input int len);
        for (int k = 0; k < len; k++) env_q.push_back(mark ? mark_lvl(k) : 1'b0);
    endtask

    task automatic send_trace(input logic [31:0] w, input string tag);
        int total;
        int env_bad  = 0;
        int rdy_bad  = 0;
        int busy_bad = 0;
        int done_cnt = 0;
        int done_cyc = 0;
        env_q.delete();
        push_seg(1'b1, 16 * T);
        push_seg(1'b0, 8 * T);
        for (int i = 0; i < 32; i++) begin
            push_seg(1'b1, T);
            push_seg(1'b0, w[i] ? 3 * T : T);
        end
        push_seg(1'b1, T);
        push_seg(1'b0, GAP * T);
        total = env_q.size();
        $display("send %s word %h", tag, w);
        accept(w);
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            if (oIRDA !== env_q[c-1]) env_bad++;
            if (oREADY !== 1'b0) rdy_bad++;
            if (oBUSY !== 1'b1) busy_bad++;
            if (oDONE === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        check({tag, "_envelope_bad_cycles"}, env_bad, 0);
        check({tag, "_ready_high_in_frame"}, rdy_bad, 0);
        check({tag, "_busy_low_in_frame"}, busy_bad, 0);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_cyc, total);
        @(negedge clk);
        check({tag, "_ready_after_done"}, oREADY, 1);
        check({tag, "_done_dropped"}, oDONE, 0);
    endtask

    initial begin
        int k;
        int bad;
        logic [31:0] wb;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", oREADY, 1);
        check("rst_busy", oBUSY, 0);
        check("rst_done", oDONE, 0);
        check("rst_irda", oIRDA, 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef IR_TX_CARRIER_EN
        send_trace(32'h0000_0001, "carrier_w1");
        exp_q.delete();
        send_trace(32'h0000_00A5, "carrier_wA5");
        exp_q.delete();
`else
        send_trace(32'h0000_0000, "zeros");
        wait_frames(1);
        send_trace(32'hFFFF_FFFF, "ones");
        wait_frames(2);
        send_trace(32'h00FF_20DF, "loopback");
        wait_frames(3);
        wb  = 32'h00FF_20DF;
        bad = 0;
        for (int i = 0; i < 32; i++) if (dec_space[i] != (wb[i] ? 3 * T : T)) bad++;
        check("loopback_space_lengths", bad, 0);

        // Back-to-back with iVALID held; the word on iDATA during the frame must be ignored.
        $display("send b2b words a1b2c3d4 then 13579bdf");
        @(negedge clk);
        k = 0;
        while (oREADY !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        iDATA  = 32'hA1B2_C3D4;
        iVALID = 1'b1;
        exp_q.push_back(iDATA);
        @(posedge clk);
        #1;
        iDATA = 32'h5555_AAAA;
        @(negedge clk);
        k = 0;
        while (oDONE !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("b2b_done_seen", oDONE, 1);
        iDATA = 32'h1357_9BDF;
        exp_q.push_back(iDATA);
        @(negedge clk);
        check("b2b_ready_after_done", oREADY, 1);
        check("b2b_done_dropped", oDONE, 0);
        @(posedge clk);
        #1;
        iVALID = 1'b0;
        iDATA  = $urandom;
        @(negedge clk);
        check("b2b_second_start_irda", oIRDA, 1);
        check("b2b_second_start_busy", oBUSY, 1);
        wait_frames(5);
        // Low time between frames: the full gap plus the single IDLE cycle carrying the accept.
        check("b2b_interframe_low", lead_gap, GAP * T + 1);

        // Reset while the mark of bit 10 is on the air.
        $display("send reset_test word 12345678 (abandoned at bit 10)");
        accept(32'h1234_5678);
        k = 0;
        while (!(dec_bits == 10 && oIRDA === 1'b1) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("rst_reached_bit10", dec_bits, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_irda", oIRDA, 0);
        check("midrst_ready", oREADY, 1);
        check("midrst_busy", oBUSY, 0);
        check("midrst_done", oDONE, 0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_ready", oREADY, 1);
        check("postrst_irda", oIRDA, 0);
        send_trace(32'hC0DE_0A5F, "after_reset");
        wait_frames(6);
        check("decoder_errors", dec_err, 0);
        check("scoreboard_drained", exp_q.size(), 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
